target_sequencer: RTL
=====================

# target_sequencer

Game-round controller sitting directly downstream of the 4-bit random generator. It pulses the generator's enable to draw a new value in the range 0–4 and turns it into a one-hot target on five lamps. It then times the player's response window, judges button hits against the target, and keeps a saturating score and a miss count that ends the game.

## Interface

Parameters:
- SHOW_TICKS, default 8: number of `tick_in` pulses a target stays lit before it times out.
- MAX_MISSES, default 3: miss count at which the game ends.
- SCORE_W, default 8: width of the score counter.

Ports:
- `target_clock` in 1: the single clock.
- `target_reset` in 1: asynchronous, active-low reset.
- `start_in` in 1: level signal; starts a game from IDLE or DONE.
- `tick_in` in 1: one-cycle game-time pulse.
- `rand_in` in 4: value from the random generator, expected 0–4.
- `rand_en` out 1: enable to the random generator.
- `hit_in` in 5: player buttons, already synchronised, active-high levels.
- `target_onehot` out 5: lamp drive.
- `score` out SCORE_W: hit count.
- `misses` out 2: miss count.
- `hit_pulse` out 1: one-cycle result strobe for a hit.
- `miss_pulse` out 1: one-cycle result strobe for a miss.
- `game_over` out 1: high while in DONE.

## Operation

- Reset values: state IDLE; all outputs 0; tick counter 0; previous target 0; internal button-history register 0.
- States and transitions:
  - IDLE: on `start_in`=1, clear score and misses, go to PICK.
  - PICK: `rand_en`=1 for exactly this cycle, then go to LATCH.
  - LATCH: sample `rand_in`. A value ≥5 returns to PICK (re-draw). Otherwise store it as the target, clear the tick counter, go to SHOW.
  - SHOW: `target_onehot` = 1<<target. Button rising edges are detected internally from `hit_in` & ~history.
    - An edge on the target bit only: hit. Score increments, saturating at all-ones. `hit_pulse` is raised. Go to PICK.
    - Any edge on a non-target bit, including in the same cycle as a target edge: miss.
    - A `tick_in` that brings the counter to SHOW_TICKS: miss (timeout).
    - If a hit edge and the timeout tick land in the same cycle, the hit wins.
    - On a miss: `misses`+1 and `miss_pulse` is raised. Go to DONE if the new count equals MAX_MISSES, else go to PICK.
  - DONE: `game_over`=1. On `start_in`=1, clear score and misses, go to PICK.
- `start_in` is ignored in PICK, LATCH and SHOW.
- `target_onehot` is 0 in every state except SHOW.
- Button history updates every cycle in every state. A button held across the entry into SHOW therefore does not register as an edge.
- `misses` never exceeds MAX_MISSES. Score holds its value in DONE until the next start.

## Timing

- `rand_en` asserted in cycle N. The generator updates on the edge ending cycle N, and `rand_in` is sampled in cycle N+1 (LATCH).
- Lamp on at cycle N+2. Minimum start-to-lamp time is 3 cycles.
- A hit/miss strobe is registered: it is high for the single cycle after the SHOW cycle in which the decision was made. In that same cycle the block is in PICK, or DONE if the miss ended the game.
- `score` and `misses` update on the same edge that raises the strobe.
- Reset mid-game acts immediately and asynchronously: lamps, strobes and `rand_en` drop at once, and the state returns to IDLE.

## Configuration

- `TARGET_NO_REPEAT_EN`:
  - Defined: in LATCH, a valid value equal to the previous target returns to PICK for a re-draw. At most 3 consecutive re-draws are made; the 4th valid value is accepted even if it repeats. The re-draw counter clears on entry to SHOW.
  - Undefined: the first valid value is accepted unconditionally.
  - The previous-target register exists in both builds.

## Test plan

- Reset, then `start_in`=1 for one cycle with `rand_in`=2 → `rand_en` high exactly one cycle. `target_onehot`=5'b00100 two cycles after `rand_en`. Score=0, misses=0.
- Target 2 lit, raise `hit_in`[2] → `hit_pulse` for one cycle, score=1, lamp off, new `rand_en` pulse follows.
- Target 2 lit, no input, 8 `tick_in` pulses → `miss_pulse` on the 8th, misses=1. Repeat until misses=3 → `game_over`=1, score held, lamps 0.
- `hit_in`=5'b00101 edge with target 2 → miss, not hit. Separately, a hit edge coinciding with the 8th tick → hit, score+1.
- `rand_in`=7 in LATCH → second `rand_en` pulse, no lamp. With `TARGET_NO_REPEAT_EN`, `rand_in` stuck at the previous target → exactly 3 re-draws, then accepted.
- Assert `target_reset` low mid-SHOW → all outputs 0 in the same cycle. Release and start again → score=0.

Source files
------------

// File: rtl/target_sequencer.sv
// Game-round controller: draws a 0-4 target from an external random source, lights it,
// judges button hits and timeouts, and keeps a saturating score and a miss count.
// Optional build macro TARGET_NO_REPEAT_EN: re-draws a target that repeats the previous one.
module target_sequencer #(
    parameter int SHOW_TICKS = 8,
    parameter int MAX_MISSES = 3,
    parameter int SCORE_W    = 8
) (
    input  logic               target_clock,
    input  logic               target_reset,
    input  logic               start_in,
    input  logic               tick_in,
    input  logic [3:0]         rand_in,
    output logic               rand_en,
    input  logic [4:0]         hit_in,
    output logic [4:0]         target_onehot,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         misses,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic               game_over
);

    localparam int TICK_W = $clog2(SHOW_TICKS + 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PICK  = 3'd1;
    localparam logic [2:0] ST_LATCH = 3'd2;
    localparam logic [2:0] ST_SHOW  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [2:0]         target_q, target_d;
    logic [2:0]         prev_target_q, prev_target_d;
    logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [1:0]         misses_q, misses_d;
    logic               hit_pulse_q, hit_pulse_d;
    logic               miss_pulse_q, miss_pulse_d;
    logic [4:0]         hist_q;

    logic [4:0]         target_mask;
    logic [4:0]         rises;
    logic               target_edge;
    logic               wrong_edge;
    logic               is_hit;
    logic               timeout;
    logic               rand_valid;
    logic               repeat_reject;
    logic [1:0]         misses_inc;

`ifdef TARGET_NO_REPEAT_EN
    logic [1:0]         redraw_q, redraw_d;
`endif

    assign target_mask = 5'b00001 << target_q;
    assign rises       = hit_in & ~hist_q;
    assign target_edge = |(rises & target_mask);
    assign wrong_edge  = |(rises & ~target_mask);
    assign is_hit      = target_edge & ~wrong_edge;
    assign timeout     = tick_in && (tick_cnt_q == TICK_W'(SHOW_TICKS - 1));
    assign rand_valid  = (rand_in < 4'd5);
    assign misses_inc  = misses_q + 2'd1;

`ifdef TARGET_NO_REPEAT_EN
    // A repeat is rejected only while the consecutive re-draw budget lasts.
    assign repeat_reject = rand_valid && (rand_in[2:0] == prev_target_q) && (redraw_q != 2'd3);
`else
    logic prev_target_unused;
    assign prev_target_unused = ^prev_target_q;
    assign repeat_reject      = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        prev_target_d = prev_target_q;
        tick_cnt_d    = tick_cnt_q;
        score_d       = score_q;
        misses_d      = misses_q;
        hit_pulse_d   = 1'b0;
        miss_pulse_d  = 1'b0;
`ifdef TARGET_NO_REPEAT_EN
        redraw_d      = redraw_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_in) begin
                    score_d  = '0;
                    misses_d = '0;
                    state_d  = ST_PICK;
                end
            end
            ST_PICK: begin
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                if (!rand_valid) begin
                    state_d = ST_PICK;
                end else if (repeat_reject) begin
`ifdef TARGET_NO_REPEAT_EN
                    redraw_d = redraw_q + 2'd1;
`endif
                    state_d = ST_PICK;
                end else begin
                    target_d      = rand_in[2:0];
                    prev_target_d = rand_in[2:0];
                    tick_cnt_d    = '0;
`ifdef TARGET_NO_REPEAT_EN
                    redraw_d      = 2'd0;
`endif
                    state_d       = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (tick_in) begin
                    tick_cnt_d = tick_cnt_q + TICK_W'(1);
                end
                // A clean target edge beats a simultaneous timeout; any wrong button is a miss.
                if (is_hit) begin
                    if (score_q != {SCORE_W{1'b1}}) begin
                        score_d = score_q + SCORE_W'(1);
                    end
                    hit_pulse_d = 1'b1;
                    state_d     = ST_PICK;
                end else if (wrong_edge || timeout) begin
                    misses_d     = misses_inc;
                    miss_pulse_d = 1'b1;
                    state_d      = (misses_inc == 2'(MAX_MISSES)) ? ST_DONE : ST_PICK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge target_clock or negedge target_reset) begin
        if (!target_reset) begin
            state_q       <= ST_IDLE;
            target_q      <= 3'd0;
            prev_target_q <= 3'd0;
            tick_cnt_q    <= '0;
            score_q       <= '0;
            misses_q      <= 2'd0;
            hit_pulse_q   <= 1'b0;
            miss_pulse_q  <= 1'b0;
            hist_q        <= 5'd0;
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            prev_target_q <= prev_target_d;
            tick_cnt_q    <= tick_cnt_d;
            score_q       <= score_d;
            misses_q      <= misses_d;
            hit_pulse_q   <= hit_pulse_d;
            miss_pulse_q  <= miss_pulse_d;
            hist_q        <= hit_in;
        end
    end

`ifdef TARGET_NO_REPEAT_EN
    always_ff @(posedge target_clock or negedge target_reset) begin
        if (!target_reset) begin
            redraw_q <= 2'd0;
        end else begin
            redraw_q <= redraw_d;
        end
    end
`endif

    assign rand_en       = (state_q == ST_PICK);
    assign target_onehot = (state_q == ST_SHOW) ? target_mask : 5'd0;
    assign game_over     = (state_q == ST_DONE);
    assign score         = score_q;
    assign misses        = misses_q;
    assign hit_pulse     = hit_pulse_q;
    assign miss_pulse    = miss_pulse_q;

endmodule
